// File: rtl/hash_display_pkg.sv
// Shared geometry, swap coordinates, colour type and hex glyph table for the
// hash_display renderer.
package hash_display_pkg;

    localparam int GLYPH_W   = 8;
    localparam int GLYPH_H   = 8;
    localparam int GRID_COLS = 16;
    localparam int GRID_ROWS = 4;
    localparam int REGION_W  = GLYPH_W * GRID_COLS;
    localparam int REGION_H  = GLYPH_H * GRID_ROWS;
    localparam int NIBBLES   = GRID_COLS * GRID_ROWS;

    localparam logic [9:0] SWAP_X = 10'd767;
    localparam logic [8:0] SWAP_Y = 9'd480;

    typedef logic [7:0] rgb332_t;

    typedef enum logic {
        SHADOW_EMPTY,
        SHADOW_FULL
    } shadow_state_t;

    // 8x8 glyph packed top row first; bit 7 of each byte is the leftmost pixel.
    function automatic logic [63:0] hex_glyph(input logic [3:0] nibble);
        logic [63:0] g;
        g = '0;
        case (nibble)
            4'h0: g = 64'h3C666E7666663C00;
            4'h1: g = 64'h1838181818187E00;
            4'h2: g = 64'h3C66060C30607E00;
            4'h3: g = 64'h3C66061C06663C00;
            4'h4: g = 64'h0C1C3C6C7E0C0C00;
            4'h5: g = 64'h7E607C0606663C00;
            4'h6: g = 64'h3C607C6666663C00;
            4'h7: g = 64'h7E060C1830303000;
            4'h8: g = 64'h3C66663C66663C00;
            4'h9: g = 64'h3C66663E060C3800;
            4'hA: g = 64'h183C66667E666600;
            4'hB: g = 64'h7C66667C66667C00;
            4'hC: g = 64'h3C66606060663C00;
            4'hD: g = 64'h786C6666666C7800;
            4'hE: g = 64'h7E60607C60607E00;
            4'hF: g = 64'h7E60607C60606000;
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_font_rom.sv
// Combinational hex font: nibble and glyph row in, 8-pixel row out
// (bit 7 is the leftmost pixel).
module hex_font_rom
    import hash_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic [2:0] row_i,
    output logic [7:0] bits_o
);

    logic [63:0] glyph;

    always_comb begin
        glyph  = hex_glyph(nibble_i);
        // {~row, 3'b000} == 8*(7-row): row 0 is the most significant byte.
        bits_o = glyph[{~row_i, 3'b000} +: 8];
    end

endmodule

// File: rtl/hash_display.sv
// Renders a 256-bit hash as a 4x16 grid of hex glyphs with a vblank-swapped
// shadow register. Optional outline enabled by HASH_DISPLAY_BORDER_EN.
module hash_display
    import hash_display_pkg::*;
#(
    parameter int      X0     = 256,
    parameter int      Y0     = 224,
    parameter rgb332_t FG     = 8'hFC,
    parameter rgb332_t BG     = 8'h03,
    parameter rgb332_t BORDER = 8'hE0
) (
    input  logic         pixel_clk,
    input  logic         reset,
    input  logic [9:0]   CounterX,
    input  logic [8:0]   CounterY,
    input  logic         inDisplayArea,
    input  logic [255:0] hash_in,
    input  logic         hash_valid,
    output logic         hash_ready,
    output rgb332_t      rgb,
    output logic         de_out
);

    localparam logic [9:0] X_LO = 10'(X0);
    localparam logic [9:0] X_HI = 10'(X0 + REGION_W);
    localparam logic [8:0] Y_LO = 9'(Y0);
    localparam logic [8:0] Y_HI = 9'(Y0 + REGION_H);

    // ---------------- hash shadow / active registers ----------------
    shadow_state_t state_q, state_d;
    logic [255:0]  shadow_q, shadow_d;
    logic [255:0]  active_q, active_d;
    logic          ready_q;
    logic          accept, swap;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        accept   = hash_valid && ready_q;
        swap     = (CounterX == SWAP_X) && (CounterY == SWAP_Y);
        case (state_q)
            SHADOW_EMPTY: begin
                // An accept on the swap cycle simply fills the shadow.
                if (accept) begin
                    shadow_d = hash_in;
                    state_d  = SHADOW_FULL;
                end
            end
            SHADOW_FULL: begin
                if (swap) begin
                    active_d = shadow_q;
                    state_d  = SHADOW_EMPTY;
                end
            end
            default: state_d = SHADOW_EMPTY;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q  <= SHADOW_EMPTY;
            shadow_q <= '0;
            active_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            ready_q  <= (state_d == SHADOW_EMPTY);
        end
    end

    assign hash_ready = ready_q;

    // ---------------- stage 1: region decode ----------------
    logic [6:0] dx;
    logic [4:0] dy;
    logic       region_d;
    logic       border_d;

    assign dx       = 7'(CounterX - X_LO);
    assign dy       = 5'(CounterY - Y_LO);
    assign region_d = (CounterX >= X_LO) && (CounterX < X_HI) &&
                      (CounterY >= Y_LO) && (CounterY < Y_HI);

`ifdef HASH_DISPLAY_BORDER_EN
    localparam logic [9:0] BX_L = 10'(X0 - 2);
    localparam logic [9:0] BX_R = 10'(X0 + REGION_W + 1);
    localparam logic [8:0] BY_T = 9'(Y0 - 2);
    localparam logic [8:0] BY_B = 9'(Y0 + REGION_H + 1);

    assign border_d = (((CounterX == BX_L) || (CounterX == BX_R)) &&
                       (CounterY >= BY_T) && (CounterY <= BY_B)) ||
                      (((CounterY == BY_T) || (CounterY == BY_B)) &&
                       (CounterX >= BX_L) && (CounterX <= BX_R));
`else
    assign border_d = 1'b0;
    // BORDER only has an effect when the outline is compiled in.
    logic unused_border;
    assign unused_border = ^BORDER;
`endif

    logic       region1_q, border1_q, de1_q;
    logic [5:0] idx1_q;
    logic [2:0] row1_q, col1_q;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            region1_q <= 1'b0;
            border1_q <= 1'b0;
            de1_q     <= 1'b0;
            idx1_q    <= '0;
            row1_q    <= '0;
            col1_q    <= '0;
        end else begin
            region1_q <= region_d;
            border1_q <= border_d;
            de1_q     <= inDisplayArea;
            idx1_q    <= {dy[4:3], dx[6:3]};
            row1_q    <= dy[2:0];
            col1_q    <= dx[2:0];
        end
    end

    // ---------------- stage 2: nibble select, font, colour ----------------
    logic [3:0] nib [NIBBLES];

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign nib[gi] = active_q[255 - 4*gi -: 4];
    end

    logic [3:0] cur_nib;
    logic [7:0] glyph_row;
    logic       pixel_on;

    assign cur_nib = nib[idx1_q];

    hex_font_rom u_font (
        .nibble_i (cur_nib),
        .row_i    (row1_q),
        .bits_o   (glyph_row)
    );

    assign pixel_on = glyph_row[3'd7 - col1_q];

    rgb332_t rgb_d, rgb_q;
    logic    de_q;

    always_comb begin
        rgb_d = '0;
        if (de1_q) begin
            if (region1_q)
                rgb_d = pixel_on ? FG : BG;
`ifdef HASH_DISPLAY_BORDER_EN
            else if (border1_q)
                rgb_d = BORDER;
`endif
        end
    end

`ifndef HASH_DISPLAY_BORDER_EN
    logic unused_border1;
    assign unused_border1 = border1_q;
`endif

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            de_q  <= de1_q;
        end
    end

    assign rgb    = rgb_q;
    assign de_out = de_q;

endmodule

// File: tb/tb_hash_display.sv
// Directed-vector bench for hash_display: reset, pixel alignment, blanking,
// border, single load and back-to-back handshakes across vblank swaps.
module tb_hash_display;

    localparam int         X0     = 256;
    localparam int         Y0     = 224;
    localparam logic [7:0] FG     = 8'hFC;
    localparam logic [7:0] BG     = 8'h03;
    localparam logic [7:0] BORDER = 8'hE0;

    localparam logic [255:0] HASH_A =
        256'h0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [255:0] HASH_E = {64{4'hE}};
    localparam logic [255:0] HASH_8 = {64{4'h8}};
    localparam logic [255:0] HASH_F = {64{4'hF}};

    logic         pixel_clk = 1'b0;
    logic         reset;
    logic [9:0]   CounterX;
    logic [8:0]   CounterY;
    logic         inDisplayArea;
    logic [255:0] hash_in;
    logic         hash_valid;
    logic         hash_ready;
    logic [7:0]   rgb;
    logic         de_out;

    int checks = 0;
    int errors = 0;

    hash_display #(
        .X0     (X0),
        .Y0     (Y0),
        .FG     (FG),
        .BG     (BG),
        .BORDER (BORDER)
    ) dut (
        .pixel_clk     (pixel_clk),
        .reset         (reset),
        .CounterX      (CounterX),
        .CounterY      (CounterY),
        .inDisplayArea (inDisplayArea),
        .hash_in       (hash_in),
        .hash_valid    (hash_valid),
        .hash_ready    (hash_ready),
        .rgb           (rgb),
        .de_out        (de_out)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic set_xy(input int x, input int y, input logic de);
        CounterX      = 10'(x);
        CounterY      = 9'(y);
        inDisplayArea = de;
    endtask

    // Present one pixel and wait the two-edge pipeline latency.
    task automatic pix(input int x, input int y, input logic de);
        set_xy(x, y, de);
        tick();
        tick();
    endtask

    task automatic do_swap();
        set_xy(767, 480, 1'b0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        hash_valid = 1'b0;
        hash_in    = '0;
        set_xy(X0 + 2, Y0, 1'b1);
        tick(); tick(); tick();
        check("rst_rgb",   32'(rgb), 32'h0);
        check("rst_ready", 32'(hash_ready), 32'h0);
        check("rst_de",    32'(de_out), 32'h0);
        reset = 1'b0;
        tick();
        check("rel_ready", 32'(hash_ready), 32'h1);

        // Active hash is zero: every cell shows '0' (row0 3C, row7 00).
        pix(X0, Y0, 1'b1);
        check("px_x0y0",    32'(rgb), 32'(BG));
        check("px_de",      32'(de_out), 32'h1);
        pix(X0 + 2, Y0, 1'b1);
        check("px_x0p2",    32'(rgb), 32'(FG));
        pix(X0 + 127, Y0 + 31, 1'b1);
        check("px_last",    32'(rgb), 32'(BG));
        pix(X0 + 128, Y0, 1'b1);
        check("px_right",   32'(rgb), 32'h0);
        pix(X0 - 1, Y0, 1'b1);
        check("px_left",    32'(rgb), 32'h0);
        pix(X0, Y0 + 32, 1'b1);
        check("px_below",   32'(rgb), 32'h0);

        set_xy(X0 + 2, Y0, 1'b1);
        tick();
        check("lat_1edge",  32'(rgb), 32'h0);
        tick();
        check("lat_2edge",  32'(rgb), 32'(FG));

        pix(X0 + 2, Y0, 1'b0);
        check("blank_rgb",  32'(rgb), 32'h0);
        check("blank_de",   32'(de_out), 32'h0);

`ifdef HASH_DISPLAY_BORDER_EN
        pix(X0 - 2, Y0 + 10, 1'b1);
        check("border_l",   32'(rgb), 32'(BORDER));
        pix(X0 + 129, Y0 - 2, 1'b1);
        check("border_cr",  32'(rgb), 32'(BORDER));
`else
        pix(X0 - 2, Y0 + 10, 1'b1);
        check("border_l",   32'(rgb), 32'h0);
        pix(X0 + 129, Y0 - 2, 1'b1);
        check("border_cr",  32'(rgb), 32'h0);
`endif

        // Single load at CounterY=100; display unchanged until the swap.
        set_xy(300, 100, 1'b1);
        hash_in    = HASH_A;
        hash_valid = 1'b1;
        tick();
        check("ld_ready",   32'(hash_ready), 32'h0);
        hash_valid = 1'b0;
        hash_in    = '0;
        tick();
        check("ld_hold",    32'(hash_ready), 32'h0);
        pix(X0 + 10, Y0, 1'b1);
        check("pre_idx1",   32'(rgb), 32'(FG));
        pix(X0 + 121, Y0 + 24, 1'b1);
        check("pre_idx63",  32'(rgb), 32'(BG));
        do_swap();
        check("sw_ready",   32'(hash_ready), 32'h1);
        pix(X0 + 10, Y0, 1'b1);
        check("post_idx1",  32'(rgb), 32'(BG));
        pix(X0 + 121, Y0 + 24, 1'b1);
        check("post_idx63a", 32'(rgb), 32'(FG));
        pix(X0 + 125, Y0 + 25, 1'b1);
        check("post_idx63b", 32'(rgb), 32'(BG));
        pix(X0 + 2, Y0, 1'b1);
        check("post_idx0",  32'(rgb), 32'(FG));

        // Back-to-back: E accepted, 8 held until the next swap.
        set_xy(300, 100, 1'b1);
        hash_in    = HASH_E;
        hash_valid = 1'b1;
        tick();
        check("bb_accA",    32'(hash_ready), 32'h0);
        hash_in = HASH_8;
        tick(); tick();
        check("bb_holdB",   32'(hash_ready), 32'h0);
        do_swap();
        check("bb_swapA",   32'(hash_ready), 32'h1);
        set_xy(X0 + 1, Y0, 1'b1);
        tick();
        check("bb_accB",    32'(hash_ready), 32'h0);
        hash_valid = 1'b0;
        tick();
        check("bb_showA",   32'(rgb), 32'(FG));
        do_swap();
        pix(X0 + 1, Y0, 1'b1);
        check("bb_showB",   32'(rgb), 32'(BG));

        // Accept on the swap cycle with the shadow empty: active unchanged.
        set_xy(767, 480, 1'b0);
        hash_in    = HASH_F;
        hash_valid = 1'b1;
        tick();
        check("sim_acc",    32'(hash_ready), 32'h0);
        hash_valid = 1'b0;
        pix(X0 + 1, Y0, 1'b1);
        check("sim_keep",   32'(rgb), 32'(BG));
        do_swap();
        pix(X0 + 1, Y0, 1'b1);
        check("sim_swap",   32'(rgb), 32'(FG));

        // Reset mid-frame with a full shadow.
        set_xy(300, 100, 1'b1);
        hash_in    = HASH_A;
        hash_valid = 1'b1;
        tick();
        hash_valid = 1'b0;
        set_xy(X0 + 1, Y0, 1'b1);
        reset = 1'b1;
        tick(); tick();
        check("mrst_rgb",   32'(rgb), 32'h0);
        check("mrst_ready", 32'(hash_ready), 32'h0);
        reset = 1'b0;
        tick();
        check("mrst_rel",   32'(hash_ready), 32'h1);
        pix(X0 + 1, Y0, 1'b1);
        check("mrst_zero",  32'(rgb), 32'(BG));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_display.md
# hash_display

Pixel-stream renderer directly downstream of the VGA `sync` timing generator. It consumes `CounterX`, `CounterY` and `inDisplayArea` on `pixel_clk` and draws the current 256-bit hash result as 64 hexadecimal glyphs in a 4×16 grid. New hashes from the mining core arrive via a valid/ready handshake into a shadow register. The shadow is promoted to the displayed register only during vertical blank, so a frame never shows a torn value.

## Interface
- `X0`, default 256: left pixel column of the text region; requires `X0 >= 2` and `X0 + 130 <= 640`.
- `Y0`, default 224: top pixel row of the text region; requires `Y0 >= 2` and `Y0 + 34 <= 480`.
- `FG`, default 8'hFC: glyph colour, RGB 3-3-2.
- `BG`, default 8'h03: colour of the text region behind the glyphs.
- `BORDER`, default 8'hE0: border colour; used only when the border is compiled in.
- `pixel_clk`, in, 1: single clock. The block uses one clock; reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high.
- `CounterX`, in, 10: horizontal count 0..767 from `sync`.
- `CounterY`, in, 9: vertical count 0..511 from `sync`; wraps naturally.
- `inDisplayArea`, in, 1: visible-pixel flag from `sync`.
- `hash_in`, in, 256: hash to display; bit 255 is the first nibble shown.
- `hash_valid`, in, 1: `hash_in` is valid.
- `hash_ready`, out, 1: the shadow register is empty and can accept a hash.
- `rgb`, out, 8: pixel colour, RGB 3-3-2.
- `de_out`, out, 1: `inDisplayArea` delayed to align with `rgb`.

## Operation
- **Region:** `CounterX` in [X0, X0+128) and `CounterY` in [Y0, Y0+32). Within it:
  - `col = (CounterX-X0)[6:3]`, `row = (CounterY-Y0)[4:3]`, `idx = row*16 + col`.
  - Nibble shown is `active[255-4*idx -: 4]`.
  - Glyph bit is `font[nibble][(CounterY-Y0)[2:0]][7-(CounterX-X0)[2:0]]`.
- **Colour selection:**
  - Glyph bit 1 gives `FG`; glyph bit 0 inside the region gives `BG`.
  - Outside the region, or with `inDisplayArea`=0, `rgb`=0.
- **Handshake:**
  - Acceptance occurs on any rising edge with `hash_valid && hash_ready`. The shadow register loads `hash_in` and `hash_ready` drops on the next edge.
  - `hash_valid` may be held asserted; data must stay stable until accepted.
- **Swap event:** `CounterX==767 && CounterY==480`, one cycle per frame.
  - If the shadow is full, `active <= shadow`, the shadow is marked empty, and `hash_ready`=1 from the next cycle.
  - If the shadow is empty, the swap does nothing.
- **Simultaneous events:**
  - Accept while the shadow is empty coincides with the swap cycle: the accept wins, the shadow becomes full, and `active` is unchanged.
  - Swap while the shadow is full: no accept is possible that cycle, because `hash_ready` is 0.
- **Reset values:** `active`=0 (screen shows 64 '0' glyphs), shadow empty, `hash_ready`=0 during reset and 1 on the first cycle after, `rgb`=0, `de_out`=0.
- **Reset mid-frame:** all state returns to reset values on the same edge. Rendering restarts from the incoming counters with no frame resync needed.

## Timing
- Pipeline latency is 2 cycles: counters sampled at edge n appear on `rgb` and `de_out` after edge n+2.
  - Stage 1 registers the region flag, `idx`, glyph row/column, border flag and `inDisplayArea`.
  - Stage 2 performs nibble select and font lookup and registers `rgb`.
- `sync` already registers HS/VS by one cycle. The integrator adds one more cycle of delay on the sync outputs to match `rgb`.
- `hash_ready` is a registered output with no combinational path from `hash_valid`.
- Throughput: at most one hash per frame (768×512 clocks). Further hashes are back-pressured.

## Configuration
- `HASH_DISPLAY_BORDER_EN` defined: a 1-pixel rectangle is drawn in `BORDER`.
  - Columns X0-2 and X0+129, rows Y0-2 through Y0+33.
  - Rows Y0-2 and Y0+33, columns X0-2 through X0+129.
  - The border has priority over `BG`; it lies outside the text region, so it never overlaps `FG`.
- Not defined: no border logic is generated; pixels on those coordinates follow the outside-region rule (`rgb`=0).

## Structure
- **Package `hash_display_pkg`** holds:
  - glyph width/height (8), grid columns/rows (16/4), region width/height (128/32);
  - the swap coordinates (767, 480);
  - an RGB 3-3-2 colour typedef.
- **Sub-module `hex_font_rom`:** combinational, 4-bit nibble + 3-bit row in, 8-bit glyph row out; bit 7 is the leftmost pixel; 0–9, A–F.

## Test plan
- **Reset:** assert `reset` for 3 cycles mid-line → `rgb`=0 and `hash_ready`=0 during reset; `hash_ready`=1 the cycle after release; the next frame renders '0' glyphs at (X0,Y0).
- **Single load:** `hash_in`=256'h0123…CDEF pulsed at CounterY=100 → accepted; the current frame is still all '0'; from the frame after the swap at (767,480), the glyph at idx 1 is '1' and at idx 63 is 'F'.
- **Back-to-back:** present hash A then B → A accepted, `hash_ready`=0 and B held until the swap; B accepted the cycle after; A is displayed one frame and B the next.
- **Pixel alignment:** CounterX=X0, CounterY=Y0 with active nibble 0 → `rgb`=`FG` or `BG` exactly 2 edges later, per font row 0 bit 7; CounterX=X0+128 → `rgb`=0.
- **Blanking:** `inDisplayArea`=0 inside region coordinates → `rgb`=0 and `de_out`=0 with 2-cycle delay.
- **Border:** with `HASH_DISPLAY_BORDER_EN`, (X0-2, Y0+10) → `BORDER`; without it → 0.
